// File: rtl/filter_peak_sequencer.sv
// Pulse-height event sequencer: waits out filter settling, finds threshold crossings,
// captures the peak over a fixed window and hands records out through a one-deep slot.
module filter_peak_sequencer #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int THRESHOLD = 100,
  parameter int SETTLE    = 32,
  parameter int PEAK_WIN  = 16,
  parameter int DEAD      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] filt_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_amp,
  output logic [TS_W-1:0]   ev_time,
  output logic              ev_pileup,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int MAX_SP  = (SETTLE > PEAK_WIN) ? SETTLE : PEAK_WIN;
  localparam int MAX_CNT = (MAX_SP > DEAD) ? MAX_SP : DEAD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  WIN_END     = CNT_W'(PEAK_WIN);
  localparam logic [CNT_W-1:0]  DEAD_LAST   = CNT_W'(DEAD - 1);
  localparam logic [DATA_W-1:0] THRESH      = DATA_W'(THRESHOLD);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_OFF,
    ST_IDLE,
    ST_ARM,
    ST_DEAD,
    ST_REARM
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [TS_W-1:0]   cross_ts_q, cross_ts_d;
  logic              pileup_q, pileup_d;
  logic              below_q, below_d;
  logic              ev_valid_q, ev_valid_d;
  logic [DATA_W-1:0] ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]   ev_time_q, ev_time_d;
  logic              ev_pileup_q, ev_pileup_d;
  logic [15:0]       drop_q, drop_d;
  logic              above;
  logic              offer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ts_d        = ts_q + TS_W'(1);
    amp_d       = amp_q;
    cross_ts_d  = cross_ts_q;
    pileup_d    = pileup_q;
    below_d     = below_q;
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_time_d   = ev_time_q;
    ev_pileup_d = ev_pileup_q;
    drop_d      = drop_q;
    offer       = 1'b0;
    above       = (filt_data > THRESH);

    if (ev_ready) begin
      ev_valid_d = 1'b0;
    end

    // Losing enable abandons any event in flight; the output slot is left alone.
    if (!enable && (state_q != ST_OFF)) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (enable) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
        ST_IDLE: begin
          if (above) begin
            state_d    = ST_ARM;
            amp_d      = filt_data;
            cross_ts_d = ts_q;
            pileup_d   = 1'b0;
            below_d    = 1'b0;
            cnt_d      = CNT_W'(1);
          end
        end
        ST_ARM: begin
          if (cnt_q == WIN_END) begin
            offer   = 1'b1;
            state_d = ST_DEAD;
            cnt_d   = '0;
          end else begin
            if (filt_data > amp_q) begin
              amp_d = filt_data;
            end
            // A dip below threshold followed by a fresh crossing marks a pile-up.
            if (!above) begin
              below_d = 1'b1;
            end else if (below_q) begin
              pileup_d = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ST_REARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REARM: begin
          if (!above) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (offer) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d  = 1'b1;
        ev_amp_d    = amp_q;
        ev_time_d   = cross_ts_q;
        ev_pileup_d = pileup_q;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      ts_q        <= '0;
      amp_q       <= '0;
      cross_ts_q  <= '0;
      pileup_q    <= 1'b0;
      below_q     <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_amp_q    <= '0;
      ev_time_q   <= '0;
      ev_pileup_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      amp_q       <= amp_d;
      cross_ts_q  <= cross_ts_d;
      pileup_q    <= pileup_d;
      below_q     <= below_d;
      ev_valid_q  <= ev_valid_d;
      ev_amp_q    <= ev_amp_d;
      ev_time_q   <= ev_time_d;
      ev_pileup_q <= ev_pileup_d;
      drop_q      <= drop_d;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_amp    = ev_amp_q;
  assign ev_time   = ev_time_q;
  assign ev_pileup = ev_pileup_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_OFF);

endmodule

// File: doc/filter_peak_sequencer.md
FILTER_PEAK_SEQUENCER -- requirements
Module: filter_peak_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: width of the shaped filter sample.
REQ-002 Parameter TS_W, default 32: width of the event timestamp.
REQ-003 Parameter THRESHOLD, default 100: trigger level, unsigned, compared against filt_data.
REQ-004 Parameter SETTLE, default 32: filter pipeline-fill cycles ignored after reset release or enable rise.
REQ-005 Parameter PEAK_WIN, default 16: samples searched for the maximum, counting from the crossing sample.
REQ-006 Parameter DEAD, default 8: minimum hold-off cycles after an event.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  reset, asynchronous, active-low.
REQ-009 enable  input  1  acquisition enable, synchronous.
REQ-010 filt_data  input  DATA_W  unsigned filter output, one sample per clk.
REQ-011 ev_valid  output  1  event record available.
REQ-012 ev_ready  input  1  consumer accepts the record.
REQ-013 ev_amp  output  DATA_W  peak amplitude.
REQ-014 ev_time  output  TS_W  timestamp of the crossing sample.
REQ-015 ev_pileup  output  1  second crossing detected inside the peak window.
REQ-016 drop_cnt  output  16  events lost to back-pressure, saturating.
REQ-017 busy  output  1  high in every state except IDLE and OFF.

Function
REQ-018 The timestamp counter shall increment by 1 every clk out of reset, independent of enable, and wrap from 2^TS_W-1 to 0.
REQ-019 States shall be SETTLE, OFF, IDLE, ARM, DEAD, REARM; reset shall enter SETTLE.
REQ-020 SETTLE: count SETTLE cycles ignoring filt_data, then go to IDLE; if enable is low, go to OFF immediately.
REQ-021 OFF: on enable high, go to SETTLE with the counter cleared.
REQ-022 In any state other than OFF, enable low shall move to OFF next cycle and discard any in-progress event; a pending ev_valid record is kept.
REQ-023 IDLE: on sample N with filt_data > THRESHOLD (strict), latch amp=filt_data and ts=timestamp, clear pileup, and go to ARM.
REQ-024 ARM: on samples N+1..N+PEAK_WIN-1, set amp=filt_data when filt_data > amp; on an equal value, keep the first.
REQ-025 ARM: filt_data <= THRESHOLD followed by a later filt_data > THRESHOLD within the window shall set pileup.
REQ-026 At the end of the window the record shall be offered; if the output slot is free or being accepted that cycle, load it so ev_valid is high from edge N+PEAK_WIN; otherwise drop the event and increment drop_cnt, saturating at 0xFFFF.
REQ-027 After the offer, go to DEAD for DEAD cycles, then to REARM; REARM goes to IDLE on the first sample with filt_data <= THRESHOLD.
REQ-028 Output slot: ev_valid stays high until a cycle with ev_ready=1; ev_amp, ev_time and ev_pileup shall hold stable while ev_valid=1 and ev_ready=0.
REQ-029 A transfer and a new load in the same cycle shall leave ev_valid=1 with the new record, with no bubble and no drop.
REQ-030 ev_ready while ev_valid=0 shall have no effect.
REQ-031 All comparisons shall be unsigned at DATA_W.

Reset
REQ-032 Asserting reset shall immediately clear ev_valid, ev_amp, ev_time, ev_pileup, drop_cnt, timestamp, all counters, amp and pileup, and shall set state SETTLE (busy=1).
REQ-033 Reset asserted mid-event shall discard the event with no record output.

Verification
REQ-034 Reset release with enable=1 and filt_data=500 -> no event for 32 cycles; a crossing is detected only on cycle 33.
REQ-035 After settle, pulse 0,150,300,450,400,200,0 with ev_ready=1 -> one record with ev_amp=450 and ev_time=timestamp at the 150 sample, ev_pileup=0, ev_valid high 16 cycles after the crossing for 1 cycle.
REQ-036 Within the window, 150,300,50,200 -> ev_pileup=1 and ev_amp=300.
REQ-037 ev_ready held 0, two pulses 60 cycles apart -> first record held stable, second dropped, drop_cnt=1; ev_ready=1 then releases the first record.
REQ-038 Input held at 300 after an event -> no second event until filt_data falls to <=100 and re-crosses.
REQ-039 enable dropped during ARM -> no record, state OFF; enable restored -> 32-cycle settle, then normal detection.
